pipereg_skid: RTL and testbench
===============================

Name: pipereg_skid

Overview:
- Parametrised successor of the fixed inter-stage pipeline registers (IF/ID … MEM/WB).
- Carries one packed payload of W bits between two pipeline stages using a valid/ready handshake.
- Has a 2-entry skid buffer, so up_ready depends only on registered state plus en and never on dn_ready.
- Adds synchronous flush, global enable, bubble-safe control masking and a saturating stall-cycle counter; the fixed registers have none of these except flush and enable.

Parameters:
W, 96, payload width in bits (packed stage fields).
CTRL_W, 4, number of payload LSBs that are control bits (wr_en, sel_data, …); must satisfy 1 <= CTRL_W <= W.
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  input  1  clock, rising edge.
nrst  input  1  reset, synchronous, active-low.
en  input  1  global enable; 0 freezes all state.
flush  input  1  synchronous flush; empties the stage.
up_valid  input  1  upstream payload valid.
up_ready  output  1  stage can accept this cycle.
up_data  input  W  upstream payload.
dn_valid  output  1  payload available downstream.
dn_ready  input  1  downstream accepts this cycle.
dn_data  output  W  downstream payload.
occupancy  output  2  number of held entries: 0, 1 or 2.
stall_cnt  output  CNT_W  cycles with dn_valid=1 and dn_ready=0, saturating.

Behaviour:
- Storage:
  - main register (main_data, main_v) drives downstream.
  - skid register (skid_data, skid_v).
  - occupancy = main_v + skid_v. The state skid_v=1 with main_v=0 is illegal and must never occur.
- Combinational outputs:
  - up_ready = en & ~skid_v.
  - dn_valid = en & main_v.
  - dn_data = main_data, with bits [CTRL_W-1:0] forced to 0 whenever dn_valid=0. A bubble never shows an asserted control bit.
- Transfers: acc = up_valid & up_ready; fire = dn_valid & dn_ready. Both already include en.
- Transitions when not in reset and flush=0:
  - EMPTY (occ 0): acc → ONE, main_data<=up_data, main_v<=1.
  - ONE (occ 1), acc & fire: main_data<=up_data, stay ONE (full throughput, one payload per cycle).
  - ONE, acc only: skid_data<=up_data, skid_v<=1 → FULL.
  - ONE, fire only: main_v<=0 → EMPTY. main_data is held but masked on output.
  - FULL (occ 2): up_ready=0. fire → main_data<=skid_data, skid_v<=0 → ONE. No fire → hold.
- Latency and ordering:
  - Payload appears on dn_data one cycle after acceptance when the stage was EMPTY, or when it was ONE with a simultaneous fire.
  - Order is strictly FIFO.
- en=0:
  - No acc or fire possible; registers hold.
  - stall_cnt does not increment.
- flush=1, any en: next cycle main_v=skid_v=0, and main_data and skid_data are zeroed.
  - Any acc or fire occurring in the flush cycle is discarded. Upstream and downstream treat flush as killing in-flight work.
  - stall_cnt is not affected by flush, and no increment is taken in the flush cycle.
- nrst=0, highest priority, synchronous:
  - All registers are cleared, stall_cnt=0.
  - Outputs on the cycle after reset: up_ready=en, dn_valid=0, dn_data=0, occupancy=0, stall_cnt=0.
  - Reset mid-transfer discards all held payloads.
- stall_cnt:
  - Increments by 1 each cycle with dn_valid & ~dn_ready & ~flush & nrst.
  - Holds at 2^CNT_W-1, with no wrap.
- Expected RTL:
  - A single clocked always block for state, plus combinational output logic.
  - No combinational path from dn_ready to up_ready.

Test Plan:
- Reset then stream: nrst low 2 cycles, then up_valid=1 with data 1,2,3,4 and dn_ready=1 every cycle → dn_data 1,2,3,4 on consecutive cycles starting 1 cycle after first acc; occupancy stays 1; stall_cnt=0.
- Backpressure: stream 10,11,12 with dn_ready=0 → occupancy 1 then 2; up_ready=0 at occupancy 2; 12 not accepted; stall_cnt counts up. Then dn_ready=1 → outputs 10,11,12 in order, no loss or duplication.
- Flush while FULL: occupancy=2 holding A5,B6, assert flush with up_valid=1 → next cycle occupancy=0, dn_valid=0, dn_data=0, new input not stored; stall_cnt unchanged.
- Bubble masking: W=96, CTRL_W=4, accept payload with low nibble 0xF, fire it with no new input → dn_valid=0 and dn_data[3:0]=0 while upper bits remain the old value.
- Enable freeze: occupancy=1, en=0 for 5 cycles with dn_ready=0 → up_ready=0, dn_valid=0, state held, stall_cnt unchanged. en=1 → original payload reappears.
- Counter saturation: CNT_W=4, dn_ready=0 with occupancy≥1 for 20 cycles → stall_cnt=15, held; nrst pulse → 0.

Source files
------------

// File: rtl/pipereg_skid.sv
// ---------------------------------------------------------------------------
// pipereg_skid
//
// Parametrised inter-stage pipeline register with a valid/ready handshake.
// It holds up to two payloads: a main register that drives downstream and a
// skid register. Because of the skid register, o_up_ready depends only on
// registered state and i_en, and never on i_dn_ready. The block also provides:
//   - synchronous flush
//   - global enable
//   - control-bit masking on bubbles
//   - a saturating stall-cycle counter
//
// Parameters
//   W       payload width in bits
//   CTRL_W  number of payload LSBs that are control bits (1 <= CTRL_W <= W)
//   CNT_W   width of the stall-cycle counter
//
// Ports
//   clk          rising-edge clock
//   nrst         synchronous active-low reset (highest priority)
//   i_en         global enable; 0 freezes all state and blocks both handshakes
//   i_flush      synchronous flush; empties the stage and zeroes the payloads
//   i_up_valid   upstream payload valid
//   o_up_ready   stage can accept a payload this cycle
//   i_up_data    upstream payload
//   o_dn_valid   payload available downstream
//   i_dn_ready   downstream accepts this cycle
//   o_dn_data    downstream payload (control bits zero while o_dn_valid=0)
//   o_occupancy  number of held entries (0, 1 or 2)
//   o_stall_cnt  cycles with o_dn_valid=1 and i_dn_ready=0, saturating
// ---------------------------------------------------------------------------
module pipereg_skid #(
  parameter int W      = 96,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_up_valid,
  output logic             o_up_ready,
  input  logic [W-1:0]     i_up_data,
  output logic             o_dn_valid,
  input  logic             i_dn_ready,
  output logic [W-1:0]     o_dn_data,
  output logic [1:0]       o_occupancy,
  output logic [CNT_W-1:0] o_stall_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [W-1:0]     r_main_data;
  logic             r_main_v;
  logic [W-1:0]     r_skid_data;
  logic             r_skid_v;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_acc;
  logic w_fire;
  logic w_stall;

  // Ready looks only at the skid flag. This keeps i_dn_ready out of the
  // upstream timing path.
  assign o_up_ready = i_en & ~r_skid_v;
  assign o_dn_valid = i_en & r_main_v;

  assign w_acc   = i_up_valid & o_up_ready;
  assign w_fire  = o_dn_valid & i_dn_ready;
  assign w_stall = o_dn_valid & ~i_dn_ready & ~i_flush;

  assign o_occupancy = {1'b0, r_main_v} + {1'b0, r_skid_v};
  assign o_stall_cnt = r_stall_cnt;

  // A bubble keeps its stale data bits, but it must never present an
  // asserted control bit to the next stage.
  always_comb begin
    o_dn_data = r_main_data;
    if (!o_dn_valid) begin
      o_dn_data[CTRL_W-1:0] = '0;
    end
  end

  // Single state process. Priority is reset, then flush, then handshakes.
  // The encoding {skid_v, main_v} = 2'b10 is unreachable; if it ever
  // appeared, the stage would recover by emptying itself.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_main_data <= '0;
      r_main_v    <= 1'b0;
      r_skid_data <= '0;
      r_skid_v    <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      if (w_stall && (r_stall_cnt != CntMax)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (i_flush) begin
        r_main_data <= '0;
        r_main_v    <= 1'b0;
        r_skid_data <= '0;
        r_skid_v    <= 1'b0;
      end else begin
        case ({r_skid_v, r_main_v})
          2'b00: begin
            if (w_acc) begin
              r_main_data <= i_up_data;
              r_main_v    <= 1'b1;
            end
          end
          2'b01: begin
            if (w_acc && w_fire) begin
              r_main_data <= i_up_data;
            end else if (w_acc) begin
              r_skid_data <= i_up_data;
              r_skid_v    <= 1'b1;
            end else if (w_fire) begin
              r_main_v <= 1'b0;
            end
          end
          2'b11: begin
            if (w_fire) begin
              r_main_data <= r_skid_data;
              r_skid_v    <= 1'b0;
            end
          end
          default: begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipereg_skid.sv
// ---------------------------------------------------------------------------
// tb_pipereg_skid
//
// Directed bench for pipereg_skid (W=96, CTRL_W=4, CNT_W=4).
// A queue-based model of the stage predicts every output on each falling
// edge. Literal expectations at key points of each scenario pin the model.
// ---------------------------------------------------------------------------
module tb_pipereg_skid;

  localparam int W      = 96;
  localparam int CTRL_W = 4;
  localparam int CNT_W  = 4;

  logic             clk;
  logic             nrst;
  logic             en;
  logic             flush;
  logic             upValid;
  logic             upReady;
  logic [W-1:0]     upData;
  logic             dnValid;
  logic             dnReady;
  logic [W-1:0]     dnData;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] stallCnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: held payloads in arrival order, the last payload
  // seen at the head (what a bubble still shows), and the stall count.
  logic [W-1:0] modelQ[$];
  logic [W-1:0] modelHeld;
  int           modelCnt;
  bit           modelKnown = 0;

  pipereg_skid #(.W(W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .i_en        (en),
    .i_flush     (flush),
    .i_up_valid  (upValid),
    .o_up_ready  (upReady),
    .i_up_data   (upData),
    .o_dn_valid  (dnValid),
    .i_dn_ready  (dnReady),
    .o_dn_data   (dnData),
    .o_occupancy (occupancy),
    .o_stall_cnt (stallCnt)
  );

  // 10-time-unit clock period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one DUT value against an expectation and count the result.
  task automatic checkOutput(input string name, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, then return just after the next rising edge.
  task automatic applyStimulus(input logic rstN, input logic enV, input logic flushV,
                               input logic uv, input logic [W-1:0] ud, input logic dr);
    nrst    = rstN;
    en      = enV;
    flush   = flushV;
    upValid = uv;
    upData  = ud;
    dnReady = dr;
    @(posedge clk);
    #1;
  endtask

  // On each falling edge: compare the DUT outputs with the model, then
  // advance the model by the transfer rules that the next rising edge applies.
  always @(negedge clk) begin
    logic [W-1:0] expData;
    logic [W-1:0] ctrlMask;
    bit           accM;
    bit           fireM;
    ctrlMask = '0;
    ctrlMask[CTRL_W-1:0] = '1;
    if (modelKnown) begin
      if (en && modelQ.size() > 0) expData = modelQ[0];
      else                         expData = modelHeld & ~ctrlMask;
      checkOutput("up_ready",  W'(upReady),   W'(en && modelQ.size() < 2));
      checkOutput("dn_valid",  W'(dnValid),   W'(en && modelQ.size() > 0));
      checkOutput("dn_data",   dnData,        expData);
      checkOutput("occupancy", W'(occupancy), W'(modelQ.size()));
      checkOutput("stall_cnt", W'(stallCnt),  W'(modelCnt));
    end
    if (!nrst) begin
      modelQ.delete();
      modelHeld  = '0;
      modelCnt   = 0;
      modelKnown = 1;
    end else if (modelKnown) begin
      accM  = upValid && en && modelQ.size() < 2;
      fireM = en && modelQ.size() > 0 && dnReady;
      if (en && modelQ.size() > 0 && !dnReady && !flush && modelCnt < (1 << CNT_W) - 1)
        modelCnt++;
      if (flush) begin
        modelQ.delete();
        modelHeld = '0;
      end else begin
        if (fireM) void'(modelQ.pop_front());
        if (accM)  modelQ.push_back(upData);
        if (modelQ.size() > 0) modelHeld = modelQ[0];
      end
    end
  end

  initial begin
    logic [W-1:0] bubbleData;
    bubbleData = 96'hABCD_0000_1111_2222_3333_444F;
    nrst = 1'b0; en = 1'b1; flush = 1'b0; upValid = 1'b0; upData = '0; dnReady = 1'b0;

    // Reset for two cycles, then a full-throughput stream of 1..4.
    applyStimulus(0, 1, 0, 0, '0, 0);
    applyStimulus(0, 1, 0, 0, '0, 0);
    checkOutput("reset up_ready",  W'(upReady),   W'(1));
    checkOutput("reset dn_valid",  W'(dnValid),   W'(0));
    checkOutput("reset dn_data",   dnData,        '0);
    checkOutput("reset occupancy", W'(occupancy), W'(0));
    checkOutput("reset stall_cnt", W'(stallCnt),  W'(0));
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1, 1, 0, 1, W'(i), 1);
      checkOutput("stream dn_data", dnData,        W'(i));
      checkOutput("stream occ",     W'(occupancy), W'(1));
    end
    applyStimulus(1, 1, 0, 0, '0, 1);
    checkOutput("drain occ",   W'(occupancy), W'(0));
    checkOutput("drain stall", W'(stallCnt),  W'(0));

    // Backpressure: 10 and 11 are held, 12 waits until there is room.
    applyStimulus(1, 1, 0, 1, W'(10), 0);
    checkOutput("bp occ1", W'(occupancy), W'(1));
    applyStimulus(1, 1, 0, 1, W'(11), 0);
    checkOutput("bp occ2",     W'(occupancy), W'(2));
    checkOutput("bp up_ready", W'(upReady),   W'(0));
    checkOutput("bp stall1",   W'(stallCnt),  W'(1));
    applyStimulus(1, 1, 0, 1, W'(12), 0);
    checkOutput("bp stall2", W'(stallCnt), W'(2));
    checkOutput("bp head10", dnData,       W'(10));
    applyStimulus(1, 1, 0, 1, W'(12), 1);
    checkOutput("bp head11", dnData,        W'(11));
    checkOutput("bp occ1b",  W'(occupancy), W'(1));
    applyStimulus(1, 1, 0, 1, W'(12), 1);
    checkOutput("bp head12", dnData, W'(12));
    applyStimulus(1, 1, 0, 0, '0, 1);
    checkOutput("bp empty", W'(occupancy), W'(0));

    // Flush while full: the new input is dropped and the counter is kept.
    applyStimulus(1, 1, 0, 1, W'(8'hA5), 0);
    applyStimulus(1, 1, 0, 1, W'(8'hB6), 0);
    checkOutput("fl full", W'(occupancy), W'(2));
    applyStimulus(1, 1, 1, 1, W'(8'hC7), 0);
    checkOutput("fl occ",      W'(occupancy), W'(0));
    checkOutput("fl dn_valid", W'(dnValid),   W'(0));
    checkOutput("fl dn_data",  dnData,        '0);
    checkOutput("fl stall",    W'(stallCnt),  W'(3));

    // Bubble masking: control nibble cleared, upper bits kept.
    applyStimulus(1, 1, 0, 1, bubbleData, 0);
    checkOutput("bub valid data", dnData, bubbleData);
    applyStimulus(1, 1, 0, 0, '0, 1);
    checkOutput("bub dn_valid", W'(dnValid), W'(0));
    checkOutput("bub dn_data",  dnData,      96'hABCD_0000_1111_2222_3333_4440);

    // Enable freeze: nothing moves for five cycles.
    applyStimulus(1, 1, 0, 1, W'(8'h55), 0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 0, 0, 1, W'(8'h66), 0);
      checkOutput("frz up_ready", W'(upReady),   W'(0));
      checkOutput("frz occ",      W'(occupancy), W'(1));
      checkOutput("frz dn_data",  dnData,        W'(8'h50));
      checkOutput("frz stall",    W'(stallCnt),  W'(3));
    end
    applyStimulus(1, 1, 0, 0, '0, 0);
    checkOutput("frz resume data",  dnData,       W'(8'h55));
    checkOutput("frz resume stall", W'(stallCnt), W'(4));

    // Counter saturation at 15, then a reset pulse clears it.
    for (int i = 0; i < 20; i++) applyStimulus(1, 1, 0, 0, '0, 0);
    checkOutput("sat stall", W'(stallCnt), W'(15));
    applyStimulus(0, 1, 0, 1, W'(8'h77), 0);
    checkOutput("rst stall", W'(stallCnt),  W'(0));
    checkOutput("rst occ",   W'(occupancy), W'(0));
    checkOutput("rst data",  dnData,        '0);

    // Mixed traffic: valid/ready/flush/enable interleaved, checked by the model.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1, (i % 11) != 7, (i == 17) || (i == 31), (i % 3) != 0,
                    W'(i + 100), (i % 4) != 1);
    end
    applyStimulus(1, 1, 0, 0, '0, 1);
    applyStimulus(1, 1, 0, 0, '0, 1);
    applyStimulus(1, 1, 0, 0, '0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
